// File: rtl/can_errovl_frame_ctrl_pkg.sv
// Shared types for the CAN error/overload frame controller: FSM states,
// frame_type codes and bus level constants.
package can_err_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FLAG       = 3'd1,
        SUPERPOS   = 3'd2,
        DELIM_WAIT = 3'd3,
        DELIM      = 3'd4
    } state_t;

    localparam logic [1:0] FT_NONE    = 2'b00;
    localparam logic [1:0] FT_ERROR   = 2'b01;
    localparam logic [1:0] FT_OVLD    = 2'b10;
    localparam logic [1:0] FT_PASSIVE = 2'b11;

    localparam logic DOMINANT  = 1'b0;
    localparam logic RECESSIVE = 1'b1;

    // Active frames drive a dominant flag; passive error frames only listen.
    function automatic logic is_active_type(input logic [1:0] ft);
        return (ft == FT_ERROR) || (ft == FT_OVLD);
    endfunction

endpackage

// File: rtl/can_errovl_frame_ctrl.sv
// Error/overload frame controller clocked at the CAN bit sample point.
// Optional stuck-dominant timeout in DELIM_WAIT is enabled by CAN_STUCK_TIMEOUT_EN.
module can_errovl_frame_ctrl
    import can_err_pkg::*;
#(
    parameter int FLAG_LEN     = 6,
    parameter int MAX_SUPERPOS = 6,
    parameter int DELIM_LEN    = 8,
    parameter int MAX_OVLD     = 2,
    parameter int STUCK_LIMIT  = 128,
    parameter int CNT_W        = 8
) (
    input  logic       SP,
    input  logic       reset,
    input  logic       RX,
    input  logic       err_start,
    input  logic       ovld_start,
    input  logic       err_passive,
    input  logic       sof,
    output logic       TX,
    output logic       F_ITMSS,
    output logic       busy,
    output logic [1:0] frame_type,
    output logic       bit_err,
    output logic       superpos_viol,
    output logic       ovld_drop,
    output logic       stuck_dom
);

    localparam int OVLD_W = $clog2(MAX_OVLD + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]  FLAG_END     = CNT_W'(FLAG_LEN);
    localparam logic [CNT_W-1:0]  SUPERPOS_END = CNT_W'(MAX_SUPERPOS);
    localparam logic [CNT_W-1:0]  DELIM_END    = CNT_W'(DELIM_LEN - 1);
`ifdef CAN_STUCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0]  STUCK_END    = CNT_W'(STUCK_LIMIT - 1);
`endif
    localparam logic [OVLD_W-1:0] OVLD_LIMIT   = OVLD_W'(MAX_OVLD);
    localparam logic [OVLD_W-1:0] OVLD_ONE     = OVLD_W'(1);

    // The bit counter must be able to hold every terminal count without wrapping.
    if ((FLAG_LEN + MAX_SUPERPOS >= 2 ** CNT_W) || (DELIM_LEN >= 2 ** CNT_W) ||
        (STUCK_LIMIT >= 2 ** CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too small for FLAG_LEN+MAX_SUPERPOS, DELIM_LEN or STUCK_LIMIT");
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [OVLD_W-1:0] ovld_cnt;
    logic              prev_rx;

    logic [OVLD_W-1:0] ovld_base;
    logic              ovld_ok;
    logic [1:0]        err_ft;

    // sof clears the overload count before any start in the same bit is judged.
    assign ovld_base = sof ? {OVLD_W{1'b0}} : ovld_cnt;
    assign ovld_ok   = (ovld_base < OVLD_LIMIT);
    assign err_ft    = err_passive ? FT_PASSIVE : FT_ERROR;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Frame FSM with all outputs registered on the sample-point edge.
    always_ff @(posedge SP) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= CNT_ZERO;
            ovld_cnt      <= {OVLD_W{1'b0}};
            prev_rx       <= RECESSIVE;
            TX            <= RECESSIVE;
            F_ITMSS       <= 1'b1;
            busy          <= 1'b0;
            frame_type    <= FT_NONE;
            bit_err       <= 1'b0;
            superpos_viol <= 1'b0;
            ovld_drop     <= 1'b0;
            stuck_dom     <= 1'b0;
        end else begin
            bit_err       <= 1'b0;
            superpos_viol <= 1'b0;
            ovld_drop     <= 1'b0;
            stuck_dom     <= 1'b0;
            F_ITMSS       <= 1'b1;
            prev_rx       <= RX;
            ovld_cnt      <= ovld_base;

            case (state)
                IDLE: begin
                    if (err_start) begin
                        state      <= FLAG;
                        cnt        <= CNT_ONE;
                        frame_type <= err_ft;
                        TX         <= err_passive;
                        busy       <= 1'b1;
                    end else if (ovld_start && ovld_ok) begin
                        state      <= FLAG;
                        cnt        <= CNT_ONE;
                        frame_type <= FT_OVLD;
                        TX         <= DOMINANT;
                        busy       <= 1'b1;
                        ovld_cnt   <= ovld_base + OVLD_ONE;
                    end else begin
                        ovld_drop  <= ovld_start;
                        state      <= IDLE;
                        cnt        <= CNT_ZERO;
                        frame_type <= FT_NONE;
                        TX         <= RECESSIVE;
                        busy       <= 1'b0;
                    end
                end

                FLAG: begin
                    if (is_active_type(frame_type)) begin
                        bit_err <= (RX == RECESSIVE);
                    end else begin
                        bit_err <= 1'b0;
                    end
                    if (cnt == FLAG_END) begin
                        state <= SUPERPOS;
                        cnt   <= CNT_ZERO;
                        TX    <= RECESSIVE;
                    end else if (is_active_type(frame_type)) begin
                        cnt <= sat_inc(cnt);
                    end else begin
                        // A passive flag needs FLAG_LEN equal bits in a row.
                        cnt <= (RX == prev_rx) ? sat_inc(cnt) : CNT_ONE;
                    end
                end

                SUPERPOS: begin
                    if (RX == RECESSIVE) begin
                        state <= DELIM;
                        cnt   <= CNT_ONE;
                    end else if (cnt == SUPERPOS_END) begin
                        superpos_viol <= 1'b1;
                        state         <= DELIM_WAIT;
                        cnt           <= CNT_ZERO;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end

                DELIM_WAIT: begin
                    if (err_start) begin
                        state      <= FLAG;
                        cnt        <= CNT_ONE;
                        frame_type <= err_ft;
                        TX         <= err_passive;
                    end else if (RX == RECESSIVE) begin
                        state <= DELIM;
                        cnt   <= CNT_ONE;
                    end
`ifdef CAN_STUCK_TIMEOUT_EN
                    else if (cnt == STUCK_END) begin
                        stuck_dom  <= 1'b1;
                        state      <= IDLE;
                        cnt        <= CNT_ZERO;
                        frame_type <= FT_NONE;
                        busy       <= 1'b0;
                        TX         <= RECESSIVE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
`else
                    else begin
                        cnt <= cnt;
                    end
`endif
                end

                DELIM: begin
                    if (err_start) begin
                        state      <= FLAG;
                        cnt        <= CNT_ONE;
                        frame_type <= err_ft;
                        TX         <= err_passive;
                    end else if (RX == RECESSIVE) begin
                        if (cnt == DELIM_END) begin
                            F_ITMSS    <= 1'b0;
                            state      <= IDLE;
                            cnt        <= CNT_ZERO;
                            frame_type <= FT_NONE;
                            busy       <= 1'b0;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end else if (cnt == DELIM_END) begin
                        // Dominant last delimiter bit is an overload condition.
                        if (ovld_ok) begin
                            state      <= FLAG;
                            cnt        <= CNT_ONE;
                            frame_type <= FT_OVLD;
                            TX         <= DOMINANT;
                            ovld_cnt   <= ovld_base + OVLD_ONE;
                        end else begin
                            ovld_drop <= 1'b1;
                            state     <= DELIM_WAIT;
                            cnt       <= CNT_ZERO;
                        end
                    end else begin
                        bit_err <= 1'b1;
                        state   <= DELIM_WAIT;
                        cnt     <= CNT_ZERO;
                    end
                end

                default: begin
                    state      <= IDLE;
                    cnt        <= CNT_ZERO;
                    frame_type <= FT_NONE;
                    TX         <= RECESSIVE;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_errovl_frame_ctrl.sv
// Directed bench for can_errovl_frame_ctrl; output vector compared every bit
// against hand-computed constants.
module tb_can_errovl_frame_ctrl;

    logic       SP = 1'b0;
    logic       reset;
    logic       RX;
    logic       err_start;
    logic       ovld_start;
    logic       err_passive;
    logic       sof;
    logic       TX;
    logic       F_ITMSS;
    logic       busy;
    logic [1:0] frame_type;
    logic       bit_err;
    logic       superpos_viol;
    logic       ovld_drop;
    logic       stuck_dom;

    can_errovl_frame_ctrl dut (
        .SP            (SP),
        .reset         (reset),
        .RX            (RX),
        .err_start     (err_start),
        .ovld_start    (ovld_start),
        .err_passive   (err_passive),
        .sof           (sof),
        .TX            (TX),
        .F_ITMSS       (F_ITMSS),
        .busy          (busy),
        .frame_type    (frame_type),
        .bit_err       (bit_err),
        .superpos_viol (superpos_viol),
        .ovld_drop     (ovld_drop),
        .stuck_dom     (stuck_dom)
    );

    always #5 SP = ~SP;

    // {TX, F_ITMSS, busy, frame_type, bit_err, superpos_viol, ovld_drop, stuck_dom}
    logic [8:0] obs;
    assign obs = {TX, F_ITMSS, busy, frame_type, bit_err, superpos_viol, ovld_drop, stuck_dom};

    localparam logic [8:0] IDLE_O      = 9'b1_1_0_00_0000;
    localparam logic [8:0] DONE_O      = 9'b1_0_0_00_0000;
    localparam logic [8:0] ERR_FLAG    = 9'b0_1_1_01_0000;
    localparam logic [8:0] ERR_FLAG_BE = 9'b0_1_1_01_1000;
    localparam logic [8:0] ERR_BUSY    = 9'b1_1_1_01_0000;
    localparam logic [8:0] ERR_BE      = 9'b1_1_1_01_1000;
    localparam logic [8:0] ERR_SV      = 9'b1_1_1_01_0100;
    localparam logic [8:0] PAS_BUSY    = 9'b1_1_1_11_0000;
    localparam logic [8:0] OVL_FLAG    = 9'b0_1_1_10_0000;
    localparam logic [8:0] OVL_BUSY    = 9'b1_1_1_10_0000;
    localparam logic [8:0] OVL_DROP    = 9'b1_1_1_10_0010;
    localparam logic [8:0] IDLE_DROP   = 9'b1_1_0_00_0010;
    localparam logic [8:0] STUCK_O     = 9'b1_1_0_00_0001;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rx_v, input logic es, input logic os, input logic sf);
        RX         = rx_v;
        err_start  = es;
        ovld_start = os;
        sof        = sf;
        @(posedge SP);
        #1;
    endtask

    task automatic step(input string tag, input logic rx_v, input logic es, input logic os,
                        input logic sf, input logic [8:0] exp);
        drive(rx_v, es, os, sf);
        check_eq(tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, IDLE_O);
        reset = 1'b0;
    endtask

    // Overload, second overload via dominant last delimiter bit, third refused,
    // refused again from IDLE, then accepted after sof.
    task automatic run_ovl_limit(input string pfx);
        logic [8:0] e;
        step($sformatf("%s_start", pfx), 1'b0, 1'b0, 1'b1, 1'b0, OVL_FLAG);
        for (int f = 0; f < 2; f++) begin
            for (int k = 1; k <= 14; k++) begin
                if (k <= 5)       e = OVL_FLAG;
                else if (k <= 13) e = OVL_BUSY;
                else              e = (f == 0) ? OVL_FLAG : OVL_DROP;
                step($sformatf("%s_f%0d_k%0d", pfx, f, k),
                     (k <= 6 || k == 14) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, e);
            end
        end
        for (int k = 15; k <= 22; k++)
            step($sformatf("%s_end_k%0d", pfx, k), 1'b1, 1'b0, 1'b0, 1'b0,
                 (k < 22) ? OVL_BUSY : DONE_O);
        step($sformatf("%s_refused", pfx), 1'b1, 1'b0, 1'b1, 1'b0, IDLE_DROP);
        step($sformatf("%s_sof_accept", pfx), 1'b1, 1'b0, 1'b1, 1'b1, OVL_FLAG);
    endtask

    initial begin
        reset       = 1'b1;
        RX          = 1'b1;
        err_start   = 1'b0;
        ovld_start  = 1'b0;
        err_passive = 1'b0;
        sof         = 1'b0;
        do_reset();

        // Active error frame on a clean bus.
        for (int i = 0; i <= 20; i++)
            step($sformatf("act%0d", i), (i < 12) ? 1'b0 : 1'b1, i == 0, 1'b0, 1'b0,
                 (i < 6) ? ERR_FLAG : (i < 19) ? ERR_BUSY : (i == 19) ? DONE_O : IDLE_O);

        // Superposition overflow after the 7th extra dominant bit.
        for (int i = 0; i <= 22; i++)
            step($sformatf("sup%0d", i), (i <= 13) ? 1'b0 : 1'b1, i == 0, 1'b0, 1'b0,
                 (i <= 5) ? ERR_FLAG : (i <= 12) ? ERR_BUSY : (i == 13) ? ERR_SV :
                 (i <= 20) ? ERR_BUSY : (i == 21) ? DONE_O : IDLE_O);

        // Passive flag: toggle at bit 3 restarts the equal-bit count.
        for (int i = 0; i <= 17; i++) begin
            err_passive = (i == 0);
            step($sformatf("pas%0d", i), (i <= 1) ? 1'b0 : 1'b1, i == 0, 1'b0, 1'b0,
                 (i <= 15) ? PAS_BUSY : (i == 16) ? DONE_O : IDLE_O);
        end
        err_passive = 1'b0;

        // Recessive inside own active flag, then dominant at delimiter bit 4.
        for (int i = 0; i <= 19; i++)
            step($sformatf("form%0d", i),
                 (i <= 6) ? ((i == 3) ? 1'b1 : 1'b0) : (i == 10) ? 1'b0 : 1'b1,
                 i == 0, 1'b0, 1'b0,
                 (i <= 5) ? ((i == 3) ? ERR_FLAG_BE : ERR_FLAG) : (i <= 9) ? ERR_BUSY :
                 (i == 10) ? ERR_BE : (i <= 17) ? ERR_BUSY : (i == 18) ? DONE_O : IDLE_O);

        // Bus held dominant while waiting for a delimiter.
        for (int i = 0; i <= 13; i++)
            drive(1'b0, i == 0, 1'b0, 1'b0);
        check_eq("stuck_entry", obs, ERR_SV);
        for (int d = 1; d <= 130; d++) begin
`ifdef CAN_STUCK_TIMEOUT_EN
            step($sformatf("stuck%0d", d), 1'b0, 1'b0, 1'b0, 1'b0,
                 (d < 128) ? ERR_BUSY : (d == 128) ? STUCK_O : IDLE_O);
`else
            step($sformatf("stuck%0d", d), 1'b0, 1'b0, 1'b0, 1'b0, ERR_BUSY);
`endif
        end
        for (int i = 0; i < 9; i++)
            drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("stuck_recover", obs, IDLE_O);

        do_reset();
        run_ovl_limit("ovl1");

        // Reset at superposition bit 2 of the accepted overload frame.
        for (int i = 1; i <= 8; i++)
            step($sformatf("rstmid%0d", i), 1'b0, 1'b0, 1'b0, 1'b0,
                 (i <= 5) ? OVL_FLAG : OVL_BUSY);
        reset = 1'b1;
        step("rst_mid_frame", 1'b0, 1'b0, 1'b0, 1'b0, IDLE_O);
        reset = 1'b0;

        // Overload count must be zero again after reset.
        run_ovl_limit("ovl2");
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
